// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StSign,
        StDone
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and the divider.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             div_err;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quo, rem, div_err
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quo, rem, div_err
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] part_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] part_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Shift in the next dividend bit, subtract when the divisor fits.
    always_comb begin
        shifted = {part_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // part_in < divisor, so a successful subtract always fits in WIDTH bits
        diff     = shifted[WIDTH-1:0] - divisor;
        part_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // dividend magnitude, becomes quotient
    logic [WIDTH-1:0] part_q, part_d;    // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_part;
    logic             step_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .part_in  (part_q),
        .bit_in   (acc_q[WIDTH-1]),
        .divisor  (dvs_q),
        .part_out (step_part),
        .q_bit    (step_bit)
    );

    // Operand magnitudes; the most negative value maps to its unsigned bit pattern.
    always_comb begin
        dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
        dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        part_d    = part_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor == '0 || (bus.signed_mode && bus.dividend == MOST_NEG
                                              && bus.divisor == '1)) begin
                        state_d = StDone;
                        quo_d   = '0;
                        rem_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = StCalc;
                        acc_d     = dvd_mag;
                        dvs_d     = dvs_mag;
                        part_d    = '0;
                        cnt_d     = '0;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                    end
                end
            end
            StCalc: begin
                acc_d  = {acc_q[WIDTH-2:0], step_bit};
                part_d = step_part;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                quo_d   = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
                rem_d   = neg_rem_q ? (~part_q + 1'b1) : part_q;
                err_d   = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            part_q    <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            part_q    <= part_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.quo     = quo_q;
    assign bus.rem     = rem_q;
    assign bus.div_err = err_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=8 with a result scoreboard.
module tb_seq_divider;

    typedef struct packed {
        logic [7:0] quo;
        logic [7:0] rem;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(8)) bus ();

    seq_divider #(
        .WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: language division operators, error cases by definition.
    function automatic exp_t model(input logic sm, input logic [7:0] a, input logic [7:0] b);
        exp_t m;
        logic signed [7:0] sa;
        logic signed [7:0] sd;
        m = '0;
        if (b == 8'h00 || (sm && a == 8'h80 && b == 8'hFF)) begin
            m.err = 1'b1;
        end else if (sm) begin
            sa    = a;
            sd    = b;
            m.quo = sa / sd;
            m.rem = sa % sd;
        end else begin
            m.quo = a / b;
            m.rem = a % b;
        end
        return m;
    endfunction

    // poke > 0: extra start pulse at that busy cycle; poke < 0: start during DONE.
    task automatic do_div(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input int poke);
        exp_t e;
        exp_t got_e;
        int   n;
        int   exp_lat;
        e = model(sm, a, b);
        sb.push_back(e);
        exp_lat = e.err ? 1 : 10;
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.dividend    = a;
        bus.divisor     = b;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'($urandom);
        bus.dividend    = 8'($urandom);
        bus.divisor     = 8'($urandom);
        check_val("busy_after_accept", 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.done && n < 40) begin
            bus.start = (n == poke);
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check_val("done_latency", 32'(n), 32'(exp_lat));
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check_val("quo", 32'(bus.quo), 32'(got_e.quo));
            check_val("rem", 32'(bus.rem), 32'(got_e.rem));
            check_val("div_err", 32'(bus.div_err), 32'(got_e.err));
        end
        if (poke < 0) begin
            bus.start    = 1'b1;
            bus.dividend = 8'h09;
            bus.divisor  = 8'h03;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_val("done_single_pulse", 32'(bus.done), 32'd0);
        check_val("idle_after_done", 32'(bus.busy), 32'd0);
        check_val("quo_hold", 32'(bus.quo), 32'(e.quo));
        check_val("err_hold", 32'(bus.div_err), 32'(e.err));
    endtask

    initial begin
        int seen_done;
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.dividend    = 8'h4B;
        bus.divisor     = 8'h19;
        #12;
        @(posedge clk);
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_quo", 32'(bus.quo), 32'd0);
        check_val("rst_rem", 32'(bus.rem), 32'd0);
        check_val("rst_err", 32'(bus.div_err), 32'd0);
        rst = 1'b0;

        // First start accepted on the first edge out of reset.
        do_div(1'b0, 8'h4B, 8'h19, 0);
        do_div(1'b1, 8'hF9, 8'h02, 0);
        do_div(1'b1, 8'h07, 8'hFE, 0);
        do_div(1'b1, 8'hF9, 8'hFE, 0);
        do_div(1'b0, 8'hFF, 8'h01, 0);
        do_div(1'b1, 8'h80, 8'h01, 0);
        do_div(1'b1, 8'h80, 8'h02, 0);
        do_div(1'b0, 8'h5A, 8'h00, 0);
        do_div(1'b1, 8'h80, 8'h00, 0);
        do_div(1'b1, 8'h80, 8'hFF, 0);
        do_div(1'b0, 8'h80, 8'hFF, 0);
        do_div(1'b0, 8'hC8, 8'h07, 3);
        do_div(1'b1, 8'h85, 8'h09, -1);

        // Abort in the fifth CALC cycle.
        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.dividend    = 8'h64;
        bus.divisor     = 8'h07;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_done", 32'(bus.done), 32'd0);
        check_val("abort_quo", 32'(bus.quo), 32'd0);
        check_val("abort_rem", 32'(bus.rem), 32'd0);
        check_val("abort_err", 32'(bus.div_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        check_val("no_done_after_abort", 32'(seen_done), 32'd0);
        do_div(1'b0, 8'h64, 8'h07, 0);

        for (int i = 0; i < 24; i++) begin
            do_div(1'($urandom), 8'($urandom), 8'($urandom_range(0, 15)), 0);
        end

        check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
